// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B - Bin.
// One bit per clock, LSB first, WIDTH cycles of RUN followed by one DONE cycle.
// Handshake: start is accepted only when busy=0 (IDLE or DONE). Once accepted,
// busy stays high for exactly WIDTH cycles and done then pulses for one cycle
// with D/Bout/ovf valid; D/Bout/ovf hold until the next accepted start.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the signed overflow flag;
// without it ovf is tied to 0 and no MSB-capture flops exist.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;

  // Current bit slice: difference bit and borrow into the next position.
  logic bit_diff;
  logic bit_borrow;
  logic accept;

  assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign accept     = start && (state_q != S_RUN);

  // Next-state, datapath shift and output-register logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          d_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        br_d = bit_borrow;
        // New bits enter at the MSB so the LSB lands at D[0] after WIDTH shifts.
        d_d  = {bit_diff, d_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          bout_d  = bit_borrow;
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  // Operand MSBs are kept separately because the shift registers lose them.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = A[WIDTH-1];
      b_msb_d = B[WIDTH-1];
    end
    if (state_q == S_RUN && cnt_q == CNT_LAST) begin
      // The bit produced on the last RUN cycle is the result MSB.
      ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_diff);
    end
  end

  // Overflow flag and captured MSB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
